// File: rtl/fib_seq_engine.sv
// fib_seq_engine: computes term n of a recurrence sequence with one addition
// per clock. Supported sequences are Fibonacci, Lucas, seeded Fibonacci and
// Tribonacci. Each term register carries a poison bit. The bit marks a value
// that has lost high-order bits, so overflow is reported only for terms that
// actually reach the result position.
module fib_seq_engine #(
    parameter int WIDTH     = 8,
    parameter int IDX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [IDX_WIDTH-1:0] n,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     seed0,
    input  logic [WIDTH-1:0]     seed1,
    input  logic                 sat_en,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     a, b, c;
    logic                 pa, pb, pc;
    logic [IDX_WIDTH-1:0] cnt;
    logic [1:0]           mode_r;
    logic                 sat_r;

    logic                 accept, step_en, finish, trib;
    logic [WIDTH+1:0]     sum_ext;
    logic                 poison_new;

    // Clamp a poisoned term to all-ones when saturation is enabled.
    function automatic logic [WIDTH-1:0] sat_val(input logic [WIDTH-1:0] v,
                                                 input logic p,
                                                 input logic en);
        return (p && en) ? {WIDTH{1'b1}} : v;
    endfunction

    assign accept  = (state == IDLE) && start && !abort;
    assign step_en = (state == RUN) && !abort && (cnt != '0);
    assign finish  = (state == RUN) && !abort && (cnt == '0);
    assign trib    = (mode_r == 2'd3);

    // One adder covers both recurrences. Two guard bits catch the carry of a three-term sum.
    always_comb begin
        sum_ext    = {2'b00, a} + {2'b00, b} + (trib ? {2'b00, c} : '0);
        poison_new = (|sum_ext[WIDTH+1:WIDTH]) | pa | pb | (trib & pc);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. Abort takes priority over both start and completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (abort || cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output: busy for the whole run.
    always_comb begin
        busy = (state == RUN);
    end

    // Term window, poison bits and step counter: load seeds on accept, advance on each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a      <= '0;
            b      <= '0;
            c      <= '0;
            pa     <= 1'b0;
            pb     <= 1'b0;
            pc     <= 1'b0;
            cnt    <= '0;
            mode_r <= 2'd0;
            sat_r  <= 1'b0;
        end else if (accept) begin
            pa     <= 1'b0;
            pb     <= 1'b0;
            pc     <= 1'b0;
            cnt    <= n;
            mode_r <= mode;
            sat_r  <= sat_en;
            c      <= '0;
            case (mode)
                2'd0: begin a <= '0;         b <= WIDTH'(1); end
                2'd1: begin a <= WIDTH'(2);  b <= WIDTH'(1); end
                2'd2: begin a <= seed0;      b <= seed1;     end
                default: begin a <= '0; b <= '0; c <= WIDTH'(1); end
            endcase
        end else if (step_en) begin
            cnt <= cnt - IDX_WIDTH'(1);
            a   <= b;
            pa  <= pb;
            if (trib) begin
                b  <= c;
                pb <= pc;
                c  <= sum_ext[WIDTH-1:0];
                pc <= poison_new;
            end else begin
                b  <= sum_ext[WIDTH-1:0];
                pb <= poison_new;
            end
        end
    end

    // Completion: publish term n with its overflow flag. Outputs hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                result   <= sat_val(a, pa, sat_r);
                overflow <= pa;
            end
        end
    end

endmodule
